voice_scheduler: RTL and testbench

- Time-multiplexes the single synchronous sine-table ROM among NUM_VOICES phase-accumulator voices.
- Computes one mixed sample per audio frame.
- Sits between the frame timing (one frame_req pulse per lrck period) and the serial audio shifter.
- Delivers each mixed sample to the shifter over a valid/ready handshake.

---
 rtl/voice_scheduler.sv | 146 ++++++++++++++
 tb/tb_voice_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// Shares one synchronous sine ROM among NUM_VOICES phase-accumulator voices and
// sums their offset-removed samples into one mixed sample per audio frame.
module voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned ROM_W      = 7,
    parameter int unsigned SAMPLE_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_req,
    input  logic                          phase_clr,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0] voice_inc,
    output logic [ADDR_W-1:0]             rom_addr,
    input  logic [ROM_W-1:0]              rom_data,
    output logic [SAMPLE_W-1:0]           sample_out,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned V_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned ACC_W    = ROM_W + $clog2(NUM_VOICES);
    localparam int unsigned SHIFT    = SAMPLE_W - ACC_W;
    localparam int unsigned MIDSCALE = 1 << (ROM_W - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] ACCUM  = 2'd2;
    localparam logic [1:0] OUTPUT = 2'd3;

    logic [1:0]                state;
    logic [1:0]                next_state;
    logic [PHASE_W-1:0]        phase [NUM_VOICES];
    logic [V_W-1:0]            v;
    logic [V_W-1:0]            next_v;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   rom_off;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [SAMPLE_W-1:0] acc_ext;
    logic [PHASE_W-1:0]        inc_sel;
    logic                      start;
    logic                      drop;
    logic                      handshake;
    logic                      last_voice;
    logic                      clr_now;

    // Datapath helpers: current voice's increment and signed ROM contribution
    always_comb begin
        next_v     = v + V_W'(1);
        last_voice = (v == V_W'(NUM_VOICES - 1));
        inc_sel    = voice_inc[int'(v)*PHASE_W +: PHASE_W];
        rom_off    = $signed(ACC_W'(rom_data)) - $signed(ACC_W'(MIDSCALE));
        acc_sum    = acc + rom_off;
        acc_ext    = SAMPLE_W'(acc);
        clr_now    = (state == IDLE) && phase_clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next state; frame requests are accepted only in IDLE or on a handshake
    always_comb begin
        next_state = state;
        start      = 1'b0;
        drop       = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_req) begin
                    start      = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                drop       = frame_req;
                next_state = ACCUM;
            end
            ACCUM: begin
                drop       = frame_req;
                next_state = last_voice ? OUTPUT : FETCH;
            end
            OUTPUT: begin
                if (sample_valid && sample_ready) begin
                    handshake = 1'b1;
                    if (frame_req) begin
                        start      = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    drop = frame_req;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) phase[i] <= '0;
            v            <= '0;
            acc          <= '0;
            rom_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= drop;
            busy    <= (next_state != IDLE);
            if (clr_now) begin
                for (int i = 0; i < int'(NUM_VOICES); i++) phase[i] <= '0;
            end
            // A same-cycle clear wins over the stored phase for the first fetch
            if (start) begin
                acc      <= '0;
                v        <= '0;
                rom_addr <= clr_now ? '0 : phase[0][PHASE_W-1 -: ADDR_W];
            end
            if (state == ACCUM) begin
                if (voice_en[v]) begin
                    acc      <= acc_sum;
                    phase[v] <= phase[v] + inc_sel;
                end
                if (!last_voice) begin
                    v        <= next_v;
                    rom_addr <= phase[next_v][PHASE_W-1 -: ADDR_W];
                end
            end
            // First OUTPUT cycle publishes the finished accumulator, MSB-aligned
            if (state == OUTPUT && !sample_valid) begin
                sample_out   <= acc_ext <<< SHIFT;
                sample_valid <= 1'b1;
            end
            if (handshake) sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: ramp ROM, frame-level reference model, vector table,
// randomized frames and hand-written backpressure / reset sequences.
module tb_voice_scheduler;

    localparam int unsigned NV = 4;
    localparam int unsigned PW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned RW = 7;
    localparam int unsigned SW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_req;
    logic            phase_clr;
    logic [NV-1:0]   voice_en;
    logic [NV*PW-1:0] voice_inc;
    logic [AW-1:0]   rom_addr;
    logic [RW-1:0]   rom_data;
    logic [SW-1:0]   sample_out;
    logic            sample_valid;
    logic            sample_ready;
    logic            busy;
    logic            overrun;

    voice_scheduler #(
        .NUM_VOICES(NV), .PHASE_W(PW), .ADDR_W(AW), .ROM_W(RW), .SAMPLE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .frame_req(frame_req), .phase_clr(phase_clr),
        .voice_en(voice_en), .voice_inc(voice_inc), .rom_addr(rom_addr),
        .rom_data(rom_data), .sample_out(sample_out), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ramp ROM: rom[i] = i & 0x7F
    always_ff @(posedge clk) rom_data <= rom_addr[RW-1:0];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] m_phase [NV];

    typedef struct packed {
        logic        clr;
        logic [3:0]  en;
        logic [63:0] inc;
        logic [7:0]  addr;
        logic [15:0] sample;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One frame: sum of enabled voices' (rom - 64), phases advance afterwards
    function automatic void model_frame(input logic clr, input logic [3:0] en, input logic [63:0] inc,
                                        output logic [7:0] addr, output logic [15:0] sample);
        int acc;
        if (clr) for (int i = 0; i < int'(NV); i++) m_phase[i] = '0;
        addr = m_phase[0][15:8];
        acc  = 0;
        for (int i = 0; i < int'(NV); i++) begin
            if (en[i]) begin
                acc += int'(m_phase[i][15:8] & 8'h7F) - 64;
                m_phase[i] += inc[i*16 +: 16];
            end
        end
        sample = 16'(acc * 128);
    endfunction

    // Called at a negedge with the FSM idle; returns at the negedge where valid is seen
    task automatic do_frame(input logic clr, input int poke_at, input logic poke_req, input logic poke_clr,
                            output logic [7:0] got_addr, output logic [15:0] got_sample,
                            output int got_lat, output logic got_ovr);
        got_lat    = -1;
        got_ovr    = 1'b0;
        got_sample = '0;
        phase_clr  = clr;
        frame_req  = 1'b1;
        @(posedge clk); @(negedge clk);
        phase_clr = 1'b0;
        frame_req = 1'b0;
        got_addr  = rom_addr;
        for (int n = 0; n <= 40; n++) begin
            if (n == poke_at + 1) begin
                got_ovr   = overrun;
                frame_req = 1'b0;
                phase_clr = 1'b0;
            end
            if (sample_valid) begin
                got_lat    = n;
                got_sample = sample_out;
                break;
            end
            if (n == poke_at) begin
                frame_req = poke_req;
                phase_clr = poke_clr;
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    logic [7:0]  ea, ga;
    logic [15:0] es, gs;
    int          lat;
    logic        ovr;
    int          poke_at;
    logic        pclr;
    logic        seen;

    initial begin
        rst = 1'b0; frame_req = 1'b0; phase_clr = 1'b0; sample_ready = 1'b1;
        voice_en = '0; voice_inc = '0;
        for (int i = 0; i < int'(NV); i++) m_phase[i] = '0;

        vecs[0]  = '{1'b1, 4'h1, 64'h0000_0000_0000_0100, 8'h00, 16'hE000};
        vecs[1]  = '{1'b0, 4'h1, 64'h0000_0000_0000_0100, 8'h01, 16'hE080};
        vecs[2]  = '{1'b0, 4'h1, 64'h0000_0000_0000_0100, 8'h02, 16'hE100};
        vecs[3]  = '{1'b1, 4'h1, 64'h0000_0000_0000_0100, 8'h00, 16'hE000};
        vecs[4]  = '{1'b1, 4'hF, 64'h0000_0000_0000_0000, 8'h00, 16'h8000};
        vecs[5]  = '{1'b0, 4'hF, 64'h0000_0000_0000_0000, 8'h00, 16'h8000};
        vecs[6]  = '{1'b1, 4'h1, 64'h0000_0000_0000_8000, 8'h00, 16'hE000};
        // Ramp wraps at 0x80, so address 0x80 reads 0 like address 0
        vecs[7]  = '{1'b0, 4'h1, 64'h0000_0000_0000_8000, 8'h80, 16'hE000};
        vecs[8]  = '{1'b0, 4'h1, 64'h0000_0000_0000_8000, 8'h00, 16'hE000};
        vecs[9]  = '{1'b1, 4'h6, 64'h0000_1000_3000_0500, 8'h00, 16'hC000};
        vecs[10] = '{1'b0, 4'h6, 64'h0000_1000_3000_0500, 8'h00, 16'hE000};
        vecs[11] = '{1'b0, 4'h6, 64'h0000_1000_3000_0500, 8'h00, 16'h0000};

        repeat (3) @(negedge clk);
        chk("reset rom_addr", 64'(rom_addr), 64'd0);
        chk("reset sample_out", 64'(sample_out), 64'd0);
        chk("reset sample_valid", 64'(sample_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= sample_valid | busy;
        end
        chk("idle without frame_req", 64'(seen), 64'd0);

        for (int i = 0; i < 12; i++) begin
            voice_en  = vecs[i].en;
            voice_inc = vecs[i].inc;
            model_frame(vecs[i].clr, vecs[i].en, vecs[i].inc, ea, es);
            do_frame(vecs[i].clr, 100, 1'b0, 1'b0, ga, gs, lat, ovr);
            chk($sformatf("vec%0d rom_addr", i), 64'(ga), 64'(vecs[i].addr));
            chk($sformatf("vec%0d sample", i), 64'(gs), 64'(vecs[i].sample));
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd9);
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d valid drops", i), 64'(sample_valid), 64'd0);
        end

        // Randomized frames, some with a dropped request or ignored clear mid-frame
        for (int i = 0; i < 24; i++) begin
            voice_en  = 4'($urandom);
            voice_inc = {$urandom, $urandom};
            pclr      = ($urandom_range(0, 7) == 0);
            poke_at   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 100;
            model_frame(pclr, voice_en, voice_inc, ea, es);
            do_frame(pclr, poke_at, 1'b1, 1'($urandom_range(0, 1)), ga, gs, lat, ovr);
            chk($sformatf("rnd%0d rom_addr", i), 64'(ga), 64'(ea));
            chk($sformatf("rnd%0d sample", i), 64'(gs), 64'(es));
            chk($sformatf("rnd%0d latency", i), 64'(lat), 64'd9);
            if (poke_at != 100) chk($sformatf("rnd%0d overrun", i), 64'(ovr), 64'd1);
            @(posedge clk); @(negedge clk);
        end

        // Backpressure: dropped request in OUTPUT, then handshake with a new request
        voice_en     = 4'h1;
        voice_inc    = 64'h0000_0000_0000_0100;
        sample_ready = 1'b0;
        model_frame(1'b0, voice_en, voice_inc, ea, es);
        do_frame(1'b0, 100, 1'b0, 1'b0, ga, gs, lat, ovr);
        chk("bp sample", 64'(gs), 64'(es));
        chk("bp latency", 64'(lat), 64'd9);
        frame_req = 1'b1;
        @(posedge clk); @(negedge clk);
        frame_req = 1'b0;
        chk("bp overrun pulse", 64'(overrun), 64'd1);
        chk("bp valid held", 64'(sample_valid), 64'd1);
        chk("bp sample held", 64'(sample_out), 64'(es));
        @(posedge clk); @(negedge clk);
        chk("bp overrun one cycle", 64'(overrun), 64'd0);
        chk("bp sample still held", 64'(sample_out), 64'(es));
        sample_ready = 1'b1;
        frame_req    = 1'b1;
        model_frame(1'b0, voice_en, voice_inc, ea, es);
        @(posedge clk); @(negedge clk);
        frame_req = 1'b0;
        chk("bp valid after handshake", 64'(sample_valid), 64'd0);
        chk("bp busy through handshake", 64'(busy), 64'd1);
        chk("bp unadvanced rom_addr", 64'(rom_addr), 64'(ea));
        lat = -1;
        for (int n = 0; n <= 40; n++) begin
            if (sample_valid) begin
                lat = n;
                break;
            end
            @(posedge clk); @(negedge clk);
        end
        chk("bp back-to-back latency", 64'(lat), 64'd9);
        chk("bp back-to-back sample", 64'(sample_out), 64'(es));
        @(posedge clk); @(negedge clk);
        chk("bp idle after handshake", 64'(busy), 64'd0);

        // Asynchronous reset while a sample is being presented
        sample_ready = 1'b0;
        voice_inc    = 64'h0000_0000_0000_1300;
        model_frame(1'b0, voice_en, voice_inc, ea, es);
        do_frame(1'b0, 100, 1'b0, 1'b0, ga, gs, lat, ovr);
        chk("pre-reset valid", 64'(sample_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("async reset rom_addr", 64'(rom_addr), 64'd0);
        chk("async reset sample_out", 64'(sample_out), 64'd0);
        chk("async reset sample_valid", 64'(sample_valid), 64'd0);
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset overrun", 64'(overrun), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        sample_ready = 1'b1;
        for (int i = 0; i < int'(NV); i++) m_phase[i] = '0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= sample_valid;
        end
        chk("no valid after reset", 64'(seen), 64'd0);
        voice_inc = 64'h0000_0000_0000_0100;
        model_frame(1'b0, voice_en, voice_inc, ea, es);
        do_frame(1'b0, 100, 1'b0, 1'b0, ga, gs, lat, ovr);
        chk("post-reset rom_addr", 64'(ga), 64'(ea));
        chk("post-reset sample", 64'(gs), 64'(es));
        chk("post-reset latency", 64'(lat), 64'd9);
        @(posedge clk); @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
